// File: rtl/blockade_pkg.sv
// Shared types and constants for the blockade ROM download path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blockade_pkg;

  // Width of the HPS ioctl byte address bus.
  localparam int IOCTL_ADDR_W = 25;

  // ioctl_index slot that carries the main ROM image.
  localparam logic [7:0] ROM_INDEX_DEFAULT = 8'd0;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    READY = 2'd3
  } state_t;

endpackage

// File: rtl/blockade_hold_timer.sv
// Loadable down-counter that times the post-load core reset hold.
// Latency: o_zero reflects the count registered on the previous edge.
// Backpressure: none; i_abort wins over i_load, which wins over i_en.
//
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset (count -> 0)
//   i_load     load i_load_val into the counter
//   i_load_val value loaded on i_load
//   i_abort    cancel a running hold (count -> 0)
//   i_en       decrement while non-zero
//   o_zero     counter is at zero
module blockade_hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_abort,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_abort) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/blockade_rom_loader.sv
// Filters the HPS ioctl download into the blockade core ROM port and sequences core reset.
// Latency: 1 cycle from an accepted ioctl_wr to o_dn_wr; core reset released RESET_HOLD cycles after load ends.
// Backpressure: none; the ioctl stream cannot be stalled, out-of-window bytes are dropped and flagged.
//
// Ports:
//   i_clk_sys, i_reset                     clock and synchronous active-high reset
//   i_ioctl_download/index/wr/addr/dout    HPS download stream
//   o_dn_addr/o_dn_data/o_dn_wr            registered write port to the core
//   o_core_reset, o_rom_ready              core reset and image-valid status
//   o_rom_overflow, o_byte_count           sticky drop flag and accepted byte count
//   o_checksum, o_checksum_valid           only when BLOCKADE_ROM_CHECKSUM_EN is defined
module blockade_rom_loader
  import blockade_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX  = ROM_INDEX_DEFAULT,
  parameter int         ADDR_W     = 14,
  parameter int         ROM_BYTES  = 16384,
  parameter int         RESET_HOLD = 16
) (
  input  logic                    i_clk_sys,
  input  logic                    i_reset,
  input  logic                    i_ioctl_download,
  input  logic [7:0]              i_ioctl_index,
  input  logic                    i_ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] i_ioctl_addr,
  input  logic [7:0]              i_ioctl_dout,
  output logic [ADDR_W-1:0]       o_dn_addr,
  output logic [7:0]              o_dn_data,
  output logic                    o_dn_wr,
  output logic                    o_core_reset,
  output logic                    o_rom_ready,
  output logic                    o_rom_overflow,
  output logic [ADDR_W:0]         o_byte_count
`ifdef BLOCKADE_ROM_CHECKSUM_EN
  ,
  output logic [15:0]             o_checksum,
  output logic                    o_checksum_valid
`endif
);

  // Window limit widened to the full ioctl address so high address bits are never truncated.
  localparam logic [IOCTL_ADDR_W-1:0] ROM_LIMIT = IOCTL_ADDR_W'(ROM_BYTES);
  localparam logic [7:0]              HOLD_LOAD = 8'(RESET_HOLD - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_dn_addr;
  logic [7:0]          r_dn_data;
  logic                r_dn_wr;
  logic [ADDR_W:0]     r_byte_count;
  logic                r_rom_overflow;
  logic                r_rom_ready;
  logic                r_core_reset;

  logic w_sel, w_in_window, w_acc, w_drop;
  logic w_in_load, w_load_entry, w_wr_en, w_drop_en;
  logic w_hold_start, w_hold_en, w_hold_abort, w_hold_zero;
  logic w_count_zero, w_count_full;

  // An index change mid-load drops sel, which ends the load like a falling download.
  assign w_sel       = i_ioctl_download & (i_ioctl_index == ROM_INDEX);
  assign w_in_window = (i_ioctl_addr < ROM_LIMIT);
  assign w_acc       = w_sel & i_ioctl_wr & w_in_window;
  assign w_drop      = w_sel & i_ioctl_wr & ~w_in_window;

  assign w_count_zero = (r_byte_count == '0);
  assign w_count_full = (r_byte_count == '1);

  // State register.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_sel) w_next_state = LOAD;
      LOAD:    if (!w_sel) w_next_state = w_count_zero ? IDLE : HOLD;
      HOLD:    if (w_sel) w_next_state = LOAD;
               else if (w_hold_zero) w_next_state = READY;
      READY:   if (w_sel) w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  // State-derived controls.
  always_comb begin
    w_in_load    = (r_state == LOAD);
    w_load_entry = (r_state != LOAD) && (w_next_state == LOAD);
    w_wr_en      = w_in_load & w_acc;
    w_drop_en    = w_in_load & w_drop;
    w_hold_start = w_in_load && (w_next_state == HOLD);
    w_hold_en    = (r_state == HOLD);
    w_hold_abort = (r_state == HOLD) & w_sel;
  end

  blockade_hold_timer #(
    .CNT_W (8)
  ) u_hold_timer (
    .i_clk      (i_clk_sys),
    .i_reset    (i_reset),
    .i_load     (w_hold_start),
    .i_load_val (HOLD_LOAD),
    .i_abort    (w_hold_abort),
    .i_en       (w_hold_en),
    .o_zero     (w_hold_zero)
  );

  // Write path and load statistics.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_dn_addr      <= '0;
      r_dn_data      <= '0;
      r_dn_wr        <= 1'b0;
      r_byte_count   <= '0;
      r_rom_overflow <= 1'b0;
    end else begin
      r_dn_wr <= w_wr_en;
      if (w_wr_en) begin
        r_dn_addr <= i_ioctl_addr[ADDR_W-1:0];
        r_dn_data <= i_ioctl_dout;
      end
      if (w_load_entry) begin
        r_byte_count   <= '0;
        r_rom_overflow <= 1'b0;
      end else begin
        if (w_wr_en && !w_count_full)
          r_byte_count <= r_byte_count + {{ADDR_W{1'b0}}, 1'b1};
        if (w_drop_en)
          r_rom_overflow <= 1'b1;
      end
    end
  end

  // Status flops follow next-state so core_reset releases on the same edge rom_ready rises.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_rom_ready  <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_rom_ready  <= (w_next_state == READY);
      r_core_reset <= (w_next_state != READY);
    end
  end

  assign o_dn_addr      = r_dn_addr;
  assign o_dn_data      = r_dn_data;
  assign o_dn_wr        = r_dn_wr;
  assign o_byte_count   = r_byte_count;
  assign o_rom_overflow = r_rom_overflow;
  assign o_rom_ready    = r_rom_ready;
  assign o_core_reset   = r_core_reset;

`ifdef BLOCKADE_ROM_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge i_clk_sys) begin
    if (i_reset || w_load_entry) r_checksum <= '0;
    else if (w_wr_en)            r_checksum <= r_checksum + {8'h00, i_ioctl_dout};
  end

  assign o_checksum       = r_checksum;
  assign o_checksum_valid = r_rom_ready;
`endif

endmodule

// File: tb/tb_blockade_rom_loader.sv
// Directed self-checking bench for blockade_rom_loader.
// Latency: checks dn_wr one cycle after each ioctl_wr and the RESET_HOLD release edge.
// Backpressure: n/a.
module tb_blockade_rom_loader;
  import blockade_pkg::*;

  logic                    clk_sys = 1'b0;
  logic                    reset;
  logic                    ioctl_download;
  logic [7:0]              ioctl_index;
  logic                    ioctl_wr;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [7:0]              ioctl_dout;
  logic [13:0]             dn_addr;
  logic [7:0]              dn_data;
  logic                    dn_wr;
  logic                    core_reset;
  logic                    rom_ready;
  logic                    rom_overflow;
  logic [14:0]             byte_count;
`ifdef BLOCKADE_ROM_CHECKSUM_EN
  logic [15:0]             checksum;
  logic                    checksum_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  blockade_rom_loader #(
    .ROM_INDEX  (8'd0),
    .ADDR_W     (14),
    .ROM_BYTES  (16384),
    .RESET_HOLD (16)
  ) dut (
    .i_clk_sys        (clk_sys),
    .i_reset          (reset),
    .i_ioctl_download (ioctl_download),
    .i_ioctl_index    (ioctl_index),
    .i_ioctl_wr       (ioctl_wr),
    .i_ioctl_addr     (ioctl_addr),
    .i_ioctl_dout     (ioctl_dout),
    .o_dn_addr        (dn_addr),
    .o_dn_data        (dn_data),
    .o_dn_wr          (dn_wr),
    .o_core_reset     (core_reset),
    .o_rom_ready      (rom_ready),
    .o_rom_overflow   (rom_overflow),
    .o_byte_count     (byte_count)
`ifdef BLOCKADE_ROM_CHECKSUM_EN
    ,
    .o_checksum       (checksum),
    .o_checksum_valid (checksum_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One-cycle byte strobe; returns just after the edge that samples it.
  task automatic pulse_wr(input logic [IOCTL_ADDR_W-1:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".dn_wr"},        32'(dn_wr),        32'd0);
    check({tag, ".dn_addr"},      32'(dn_addr),      32'd0);
    check({tag, ".dn_data"},      32'(dn_data),      32'd0);
    check({tag, ".byte_count"},   32'(byte_count),   32'd0);
    check({tag, ".rom_overflow"}, 32'(rom_overflow), 32'd0);
    check({tag, ".rom_ready"},    32'(rom_ready),    32'd0);
    check({tag, ".core_reset"},   32'(core_reset),   32'd1);
`ifdef BLOCKADE_ROM_CHECKSUM_EN
    check({tag, ".checksum"},     32'(checksum),     32'd0);
    check({tag, ".cks_valid"},    32'(checksum_valid), 32'd0);
`endif
  endtask

  logic [7:0] img1 [4];
  logic [7:0] img6 [4];

  initial begin
    img1 = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    img6 = '{8'h01, 8'h02, 8'hFF, 8'hFF};
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'h00;
    tick(); tick();
    check_reset_values("rst");
    reset = 1'b0;

    // 1: four-byte image, 1-cycle write latency, 16-cycle hold release.
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      pulse_wr(IOCTL_ADDR_W'(i), img1[i]);
      check("t1.dn_wr",   32'(dn_wr),   32'd1);
      check("t1.dn_addr", 32'(dn_addr), 32'(i));
      check("t1.dn_data", 32'(dn_data), 32'(img1[i]));
    end
    tick();
    check("t1.dn_wr_pulse", 32'(dn_wr),      32'd0);
    check("t1.byte_count",  32'(byte_count), 32'd4);
    check("t1.core_reset",  32'(core_reset), 32'd1);
    ioctl_download = 1'b0;
    tick();
    repeat (15) tick();
    check("t1.hold_ready", 32'(rom_ready),  32'd0);
    check("t1.hold_crst",  32'(core_reset), 32'd1);
    tick();
    check("t1.rom_ready",  32'(rom_ready),  32'd1);
    check("t1.core_rst0",  32'(core_reset), 32'd0);

    // 2: wrong index is ignored entirely.
    reset = 1'b1; tick(); reset = 1'b0;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) pulse_wr(IOCTL_ADDR_W'(i), 8'(i + 1));
    check("t2.dn_wr",      32'(dn_wr),      32'd0);
    check("t2.dn_addr",    32'(dn_addr),    32'd0);
    check("t2.byte_count", 32'(byte_count), 32'd0);
    ioctl_download = 1'b0; ioctl_index = 8'd0;
    repeat (20) tick();
    check("t2.core_reset", 32'(core_reset), 32'd1);
    check("t2.rom_ready",  32'(rom_ready),  32'd0);

    // 3: window edge, bytes at 16384 and above are dropped.
    ioctl_download = 1'b1;
    tick();
    pulse_wr(25'd16382, 8'h11);
    check("t3.wr_16382",   32'(dn_wr),   32'd1);
    check("t3.addr_16382", 32'(dn_addr), 32'd16382);
    pulse_wr(25'd16383, 8'h22);
    check("t3.wr_16383",   32'(dn_wr),   32'd1);
    check("t3.addr_16383", 32'(dn_addr), 32'd16383);
    check("t3.data_16383", 32'(dn_data), 32'h22);
    pulse_wr(25'd16384, 8'h33);
    check("t3.wr_16384",   32'(dn_wr),   32'd0);
    check("t3.addr_hold",  32'(dn_addr), 32'd16383);
    check("t3.data_hold",  32'(dn_data), 32'h22);
    pulse_wr(25'd16385, 8'h44);
    check("t3.wr_16385",   32'(dn_wr),   32'd0);
    check("t3.byte_count", 32'(byte_count),   32'd2);
    check("t3.overflow",   32'(rom_overflow), 32'd1);
    ioctl_download = 1'b0;
    repeat (17) tick();
    check("t3.rom_ready",  32'(rom_ready),    32'd1);
    check("t3.ovf_sticky", 32'(rom_overflow), 32'd1);

    // 4: empty download from READY invalidates the image and returns to IDLE.
    ioctl_download = 1'b1;
    tick();
    check("t4.rom_ready_drop", 32'(rom_ready),    32'd0);
    check("t4.core_reset",     32'(core_reset),   32'd1);
    check("t4.count_clear",    32'(byte_count),   32'd0);
    check("t4.ovf_clear",      32'(rom_overflow), 32'd0);
    tick();
    ioctl_download = 1'b0;
    repeat (20) tick();
    check("t4.rom_ready_idle", 32'(rom_ready),  32'd0);
    check("t4.crst_idle",      32'(core_reset), 32'd1);

    // 5: download reasserted 5 cycles into HOLD aborts and restarts the hold.
    ioctl_download = 1'b1;
    tick();
    pulse_wr(25'd0, 8'h10);
    pulse_wr(25'd1, 8'h20);
    pulse_wr(25'd2, 8'h30);
    ioctl_download = 1'b0;
    tick();
    repeat (5) tick();
    ioctl_download = 1'b1;
    tick();
    check("t5.abort_count", 32'(byte_count), 32'd0);
    check("t5.abort_ready", 32'(rom_ready),  32'd0);
    pulse_wr(25'd100, 8'h77);
    pulse_wr(25'd101, 8'h88);
    check("t5.byte_count", 32'(byte_count), 32'd2);
    check("t5.dn_data",    32'(dn_data),    32'h88);
    check("t5.dn_addr",    32'(dn_addr),    32'd101);
    ioctl_download = 1'b0;
    tick();
    repeat (15) tick();
    check("t5.hold_ready", 32'(rom_ready),  32'd0);
    tick();
    check("t5.rom_ready",  32'(rom_ready),  32'd1);
    check("t5.core_rst0",  32'(core_reset), 32'd0);

    // 6: checksum image 01,02,FF,FF sums to 0x0201.
    reset = 1'b1; tick(); reset = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) pulse_wr(IOCTL_ADDR_W'(i), img6[i]);
    ioctl_download = 1'b0;
    tick();
    repeat (16) tick();
    check("t6.rom_ready",  32'(rom_ready),  32'd1);
    check("t6.byte_count", 32'(byte_count), 32'd4);
`ifdef BLOCKADE_ROM_CHECKSUM_EN
    check("t6.checksum",   32'(checksum),       32'h0201);
    check("t6.cks_valid",  32'(checksum_valid), 32'd1);
`endif

    // 7: synchronous reset mid-load, with a write presented on the reset edge.
    ioctl_download = 1'b1;
    tick();
    pulse_wr(25'd0, 8'h12);
    pulse_wr(25'd1, 8'h34);
    check("t7.byte_count", 32'(byte_count), 32'd2);
    reset = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h99;
    tick();
    check_reset_values("t7.rst");
    reset = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
